// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory helper blocks.
// Holds the default RAM geometry and the state encoding of the
// RAM read-out engine (ram_to_stream).
package mem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ram_to_stream.sv
// ram_to_stream: sequential RAM read-out engine.
// On a start pulse it walks data_memory from base_addr for length words
// and presents each word on a valid/ready stream, flagging the last one.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start               dump request, sampled only while idle
//   base_addr, length   first address / word count (0..2^ADDR_W), taken with start
//   busy                high from the cycle after an accepted start through DONE
//   done                one-cycle completion pulse
//   ram_address         RAM read address (also the running address counter)
//   ram_write           RAM write enable, tied low
//   ram_data_out        RAM read data, valid RD_LAT cycles after the address
//   out_data/out_valid/out_ready/out_last   registered output stream
module ram_to_stream
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1            // 0..3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    // WAIT counts down from RD_LAT-1; READ itself accounts for one cycle.
    localparam logic [1:0] WAIT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;
    localparam logic [ADDR_W:0] REM_ONE = (ADDR_W + 1)'(1);

    state_t            state;
    logic [ADDR_W:0]   remaining;   // one bit wider so a full-RAM dump fits
    logic [1:0]        wait_cnt;

    assign ram_write = 1'b0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
            ram_address <= '0;
            remaining   <= '0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (length != '0) begin
                            ram_address <= base_addr;
                            remaining   <= length;
                            state       <= ST_READ;
                        end else begin
                            // Empty dump: straight to completion, no beat.
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end

                ST_READ: begin
                    if (RD_LAT == 0) begin
                        out_data  <= ram_data_out;
                        out_last  <= (remaining == REM_ONE);
                        out_valid <= 1'b1;
                        state     <= ST_SEND;
                    end else begin
                        wait_cnt <= WAIT_INIT;
                        state    <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        out_data  <= ram_data_out;
                        out_last  <= (remaining == REM_ONE);
                        out_valid <= 1'b1;
                        state     <= ST_SEND;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end

                ST_SEND: begin
                    // Everything, including the address, holds until accepted.
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        out_last    <= 1'b0;
                        remaining   <= remaining - REM_ONE;
                        ram_address <= ram_address + ADDR_W'(1);
                        if (remaining == REM_ONE) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end

                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_to_stream.sv
// Bench for ram_to_stream: three instances (RD_LAT 0, 1, 2) share one
// stimulus stream. Expected beats are derived from the RAM image and the
// job parameters; per-lane monitors check data, order, last flag, timing,
// hold-under-backpressure, done/busy and reset behaviour.
module tb_ram_to_stream;
    import mem_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int NL = 3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;

    logic [NL-1:0] busy_v, done_v, wr_v, valid_v, last_v;
    logic [AW-1:0] addr_v  [NL];
    logic [DW-1:0] data_v  [NL];
    logic [DW-1:0] rdata_v [NL];

    logic [DW-1:0] ram_img [256];
    beat_t         exp_q [$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int flush_idx = 0;
    int rdy_mode = 0;   // 0: ready high, 1: random, 2: ready low

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(string nm, int lane, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s lane=%0d got=%0h want=%0h (cycle %0d)", nm, lane, act, exp, cyc);
        end
    endfunction

    initial forever begin
        @(posedge clock);
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    for (genvar g = 0; g < NL; g++) begin : gen_lane
        logic [DW-1:0] pipe [4];

        // RAM model with g cycles of read latency.
        always @(posedge clock) begin
            pipe[0] <= ram_img[addr_v[g]];
            for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
        end
        if (g == 0) begin : g_comb
            assign rdata_v[g] = ram_img[addr_v[g]];
        end else begin : g_pipe
            assign rdata_v[g] = pipe[g-1];
        end

        ram_to_stream #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(g)) dut (
            .clock        (clock),
            .reset        (reset),
            .start        (start),
            .base_addr    (base_addr),
            .length       (length),
            .busy         (busy_v[g]),
            .done         (done_v[g]),
            .ram_address  (addr_v[g]),
            .ram_write    (wr_v[g]),
            .ram_data_out (rdata_v[g]),
            .out_data     (data_v[g]),
            .out_valid    (valid_v[g]),
            .out_ready    (out_ready),
            .out_last     (last_v[g])
        );

        int            idx = 0;
        int            nva = -1;       // cycle the next out_valid must rise
        int            done_at = -1;
        int            idle_at = -1;
        logic          pv = 1'b0;
        logic          phs = 1'b0;
        logic          rst_pend = 1'b0;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        logic          pl;

        always @(negedge clock) begin
            chk("ram_write", g, 32'(wr_v[g]), 0);
            if (rst_pend) begin
                chk("reset_outputs", g,
                    32'({busy_v[g], done_v[g], valid_v[g], last_v[g], addr_v[g], data_v[g]}), 0);
                rst_pend = 1'b0;
            end
            if (reset) begin
                idx = flush_idx;
                nva = -1; done_at = -1; idle_at = -1;
                pv = 1'b0; phs = 1'b0;
                rst_pend = 1'b1;
            end else begin
                if (pv && !phs)
                    chk("hold", g, 32'({valid_v[g], data_v[g], last_v[g], addr_v[g]}),
                        32'({1'b1, pd, pl, pa}));
                if (valid_v[g] && !pv)
                    chk("valid_time", g, cyc, nva);
                if (cyc == done_at)
                    chk("done_busy", g, 32'({done_v[g], busy_v[g]}), 32'b11);
                else if (done_v[g])
                    chk("done_time", g, cyc, done_at);
                if (cyc == idle_at)
                    chk("busy_low", g, 32'(busy_v[g]), 0);
                if (start && !busy_v[g]) begin
                    if (length != 0) nva = cyc + 2 + g;
                    else begin
                        done_at = cyc + 1;
                        idle_at = cyc + 2;
                    end
                end
                phs = valid_v[g] && out_ready;
                if (phs) begin
                    if (idx < exp_q.size()) begin
                        chk("beat", g, 32'({addr_v[g], data_v[g], last_v[g]}), 32'(exp_q[idx]));
                        if (exp_q[idx].last) begin
                            done_at = cyc + 1;
                            idle_at = cyc + 2;
                        end else begin
                            nva = cyc + 2 + g;
                        end
                        idx++;
                    end else begin
                        chk("extra_beat", g, idx, exp_q.size());
                    end
                end
                pv = valid_v[g];
                pd = data_v[g];
                pl = last_v[g];
                pa = addr_v[g];
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_job(input logic [AW-1:0] b, input int n);
        beat_t e;
        start     = 1'b1;
        base_addr = b;
        length    = n[AW:0];
        for (int i = 0; i < n; i++) begin
            e.addr = b + AW'(i);
            e.data = ram_img[e.addr];
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int c = 0;
        tick();
        while (busy_v != '0 && c < maxc) begin
            tick();
            c++;
        end
        chk("idle_timeout", -1, 32'(busy_v), 0);
        tick();
    endtask

    task automatic rand_ram();
        for (int i = 0; i < 256; i++) ram_img[i] = DW'($urandom);
    endtask

    initial begin
        int c;
        for (int i = 0; i < 256; i++) ram_img[i] = DW'(i + 16);
        repeat (3) tick();
        reset = 1'b0;
        rdy_mode = 0;
        tick();

        // basic dump and address wrap
        start_job(8'h00, 4);
        wait_idle(200);
        start_job(8'hFE, 4);
        wait_idle(200);

        // backpressure stretch in the middle of a dump
        start_job(8'h20, 6);
        repeat (6) tick();
        rdy_mode = 2;
        repeat (6) tick();
        rdy_mode = 0;
        wait_idle(300);

        // zero length
        start_job(8'h33, 0);
        wait_idle(20);

        // a start pulsed mid-dump is ignored
        start_job(8'h40, 5);
        repeat (3) tick();
        start = 1'b1;
        base_addr = 8'h90;
        length = 9'd7;
        tick();
        start = 1'b0;
        wait_idle(300);

        // full RAM, crossing the top of memory
        rand_ram();
        start_job(8'h80, 256);
        wait_idle(1500);

        // reset while a beat is being offered
        rdy_mode = 2;
        tick();
        start_job(8'h10, 10);
        c = 0;
        while (valid_v != '1 && c < 50) begin
            tick();
            c++;
        end
        chk("reach_send", -1, 32'(valid_v), 32'b111);
        flush_idx = exp_q.size();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rdy_mode = 0;
        tick();
        start_job(8'hC0, 5);
        wait_idle(300);

        // random jobs with random backpressure
        rdy_mode = 1;
        repeat (8) begin
            rand_ram();
            start_job(AW'($urandom), $urandom_range(1, 20));
            wait_idle(600);
        end
        rdy_mode = 0;
        tick();

        chk("beats_consumed", 0, gen_lane[0].idx, exp_q.size());
        chk("beats_consumed", 1, gen_lane[1].idx, exp_q.size());
        chk("beats_consumed", 2, gen_lane[2].idx, exp_q.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_to_stream.md
# ram_to_stream

Sequential RAM read-out engine: on a start pulse it walks `data_memory` from a base address for a given word count and streams each word out over a valid/ready interface, with a last-word flag. It is the inverse of the file-to-RAM loader. It lets the processor's data memory be dumped to a file writer, a debug port or a downstream consumer. It drives the RAM address and write-enable directly; any sharing of the RAM with the loader is arbitrated outside this block.

## Interface
- `ADDR_W`, default 8: RAM address width.
- `DATA_W`, default 8: RAM word width.
- `RD_LAT`, default 1: cycles from `ram_address` stable to `ram_data_out` valid. 0 means combinational read. Legal range is 0..3.

- `clock`  in  1  single clock; everything updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a dump; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first address; sampled with `start`.
- `length`  in  ADDR_W+1  number of words, 0..2^ADDR_W; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted start through the DONE cycle.
- `done`  out  1  one-cycle pulse when the dump completes.
- `ram_address`  out  ADDR_W  RAM read address.
- `ram_write`  out  1  RAM write enable; constant 0.
- `ram_data_out`  in  DATA_W  RAM read data.
- `out_data`  out  DATA_W  streamed word; registered.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  the consumer accepts the word when `out_valid` and `out_ready` are both high.
- `out_last`  out  1  high with `out_valid` on the final word.

## Operation
- States: IDLE, READ, WAIT, SEND, DONE.
- **IDLE**
  - `start` with `length` ≠ 0: latch `base_addr` into the address counter and `length` into the remaining counter, then go to READ.
  - `start` with `length` = 0: go to DONE. No beat is produced.
  - `start` in any state other than IDLE is ignored.
- **READ**
  - `ram_address` = address counter.
  - If `RD_LAT` = 0: capture `ram_data_out` into `out_data` and go to SEND.
  - Otherwise: load the wait counter with `RD_LAT`-1 and go to WAIT.
- **WAIT**
  - `ram_address` is held.
  - When the wait counter reaches 0, capture `ram_data_out` and go to SEND. Otherwise decrement the counter.
- **SEND**
  - `out_valid` = 1.
  - `out_last` = 1 when remaining = 1.
  - `out_data`, `out_last` and `ram_address` are held stable until the handshake.
  - On handshake: decrement remaining and increment the address modulo 2^ADDR_W, so 0xFF wraps to 0x00.
  - After the handshake, go to DONE if this was the last word, otherwise go to READ.
- **DONE**
  - `done` = 1 for exactly one cycle, then go to IDLE.
- `length` = 2^ADDR_W (256) dumps the full RAM once. It is held in ADDR_W+1 bits, so there is no overflow.
- `ram_write` is 0 in every state, including during reset.
- Reset in any state, including mid-beat with `out_valid` high:
  - Next state is IDLE.
  - `busy`, `done`, `out_valid`, `out_last`, `ram_address` and `out_data` all go to 0.
  - The interrupted beat is dropped and never re-presented.

## Timing
- Start to first word: `start` is sampled at edge k. READ runs in cycle k+1, and the first `out_valid` is high in cycle k+2+`RD_LAT`.
- Handshake to next word: a handshake at cycle t gives the next `out_valid` at t+2+`RD_LAT`. With `out_ready` held at 1, throughput is one word per `RD_LAT`+2 cycles.
- `out_valid` never drops without a handshake or a reset.
- Completion: the last handshake at t gives `done` = 1 and `busy` = 1 at t+1. `busy` = 0 at t+2, and a new `start` is accepted at t+2.
- A zero-length start at k gives `done` at k+1.
- Backpressure: while `out_ready` = 0 in SEND there are no RAM address changes and no counter updates.

## Structure
- Shared package, `mem_pkg`:
  - `ADDR_W` and `DATA_W` defaults.
  - The state encoding for IDLE/READ/WAIT/SEND/DONE.
- No sub-module is needed; the FSM plus the address, remaining and wait counters fit in one module.
- Optional sub-module: `file_writer` is the natural sink for the stream in the top-level dump wrapper. It is not part of this block.

## Test plan
- **Basic dump:** RAM[i] = i+0x10. `start` with `base_addr`=0x00, `length`=4, `out_ready`=1, `RD_LAT`=1 → words 0x10, 0x11, 0x12, 0x13; `out_last` only on 0x13. First `out_valid` is 3 cycles after `start`; beats are 3 cycles apart. `done` pulses once, and `busy` is low 2 cycles after the last beat.
- **Wrap-around:** `base_addr`=0xFE, `length`=4 → addresses 0xFE, 0xFF, 0x00, 0x01 in order.
- **Backpressure:** `out_ready`=0 for 5 cycles on beat 2 → `out_valid`, `out_data` and `ram_address` stay stable. No beat is lost or duplicated, and the stream matches the RAM image.
- **Zero length and ignored start:** `length`=0 → `done` at k+1 with no `out_valid`. A `start` pulsed mid-dump is ignored, and the current dump completes unchanged.
- **Full RAM, both latencies:** `length`=256 with `RD_LAT`=0 and `RD_LAT`=2 → 256 beats equal to the RAM contents, with per-beat spacing of 2 and 4 cycles. `ram_write` is 0 throughout.
- **Reset mid-beat:** `reset` while in SEND with `out_valid`=1 → all outputs are 0 the next cycle. A new `start` then produces a correct dump from its own `base_addr`.
